// File: rtl/data_memory_responder.sv
// Word-addressed 16-bit data memory answering memory-stage load/store requests.
// Define MEM_BOUNDS_CHECK_EN to flag and suppress accesses beyond the array depth.
module data_memory_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req_valid,
    output logic        mem_req_ready,
    input  logic        mem_req_write,
    input  logic [15:0] mem_req_addr,
    input  logic [15:0] mem_req_wdata,
    output logic        mem_resp_valid,
    output logic [15:0] mem_resp_rdata,
    output logic        mem_resp_error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam bit LAT1  = (LATENCY == 1);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    logic [3:0] cnt;

    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;

    logic accept;
    logic go_resp;

    logic                  op_write;
    logic [15:0]           op_addr;
    logic [15:0]           op_wdata;
    logic [ADDR_WIDTH-1:0] op_idx;
    logic                  op_oob;

    logic [15:0] mem [DEPTH];

    assign mem_req_ready = !reset && (state != WAIT);
    assign accept        = mem_req_valid && mem_req_ready;

    // With single-cycle latency the accept edge is also the service edge,
    // so the operation comes straight from the request port.
    always_comb begin
        op_write = req_write;
        op_addr  = req_addr;
        op_wdata = req_wdata;
        if (LAT1 && accept) begin
            op_write = mem_req_write;
            op_addr  = mem_req_addr;
            op_wdata = mem_req_wdata;
        end
    end

    assign go_resp = (LAT1 && accept)
                  || (state == WAIT && cnt == 4'd1);

    assign op_idx = op_addr[ADDR_WIDTH-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
    assign op_oob = |op_addr[15:ADDR_WIDTH];

    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (go_resp) begin
            err_q <= op_oob;
        end
    end

    assign mem_resp_error = err_q;
`else
    logic unused_hi;

    assign op_oob         = 1'b0;
    assign unused_hi      = ^op_addr[15:ADDR_WIDTH];
    assign mem_resp_error = 1'b0;
`endif

    // Array has no reset; reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!reset && go_resp && op_write && !op_oob) begin
            mem[op_idx] <= op_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            req_write      <= 1'b0;
            req_addr       <= 16'h0000;
            req_wdata      <= 16'h0000;
            mem_resp_valid <= 1'b0;
            mem_resp_rdata <= 16'h0000;
        end else begin
            mem_resp_valid <= go_resp;

            if (go_resp) begin
                if (op_oob) begin
                    mem_resp_rdata <= 16'h0000;
                end else if (op_write) begin
                    mem_resp_rdata <= op_wdata;
                end else begin
                    mem_resp_rdata <= mem[op_idx];
                end
            end

            if (accept) begin
                req_write <= mem_req_write;
                req_addr  <= mem_req_addr;
                req_wdata <= mem_req_wdata;
                cnt       <= CNT_LOAD;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end

            unique case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        state <= LAT1 ? RESP : WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: LATENCY=2 instance plus a
// LATENCY=1 instance for back-to-back single-cycle service.
module tb_data_memory_responder;

    logic        clk;
    logic        reset;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_error;

    logic        v1;
    logic        rdy1;
    logic        w1;
    logic [15:0] a1;
    logic [15:0] d1;
    logic        rv1;
    logic [15:0] rd1;
    logic        re1;

    int checks;
    int errors;

    data_memory_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (req_valid),
        .mem_req_ready  (req_ready),
        .mem_req_write  (req_write),
        .mem_req_addr   (req_addr),
        .mem_req_wdata  (req_wdata),
        .mem_resp_valid (resp_valid),
        .mem_resp_rdata (resp_rdata),
        .mem_resp_error (resp_error)
    );

    data_memory_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut1 (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (v1),
        .mem_req_ready  (rdy1),
        .mem_req_write  (w1),
        .mem_req_addr   (a1),
        .mem_req_wdata  (d1),
        .mem_resp_valid (rv1),
        .mem_resp_rdata (rd1),
        .mem_resp_error (re1)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v);
        @(negedge clk);
        chk({v.name, " ready_idle"}, 16'(req_ready), 16'd1);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk({v.name, " valid_c1"}, 16'(resp_valid), 16'd0);
        chk({v.name, " ready_c1"}, 16'(req_ready), 16'd0);
        @(negedge clk);
        chk({v.name, " valid_c2"}, 16'(resp_valid), 16'd1);
        chk({v.name, " rdata"}, resp_rdata, v.exp_rdata);
        chk({v.name, " error"}, 16'(resp_error), 16'(v.exp_err));
        chk({v.name, " ready_c2"}, 16'(req_ready), 16'd1);
        @(negedge clk);
        chk({v.name, " valid_c3"}, 16'(resp_valid), 16'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        clk       = 1'b0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        v1        = 1'b0;
        w1        = 1'b0;
        a1        = 16'h0000;
        d1        = 16'h0000;

        vecs[0]  = '{"st_a5",  1'b1, 16'h00A5, 16'hBEEF, 16'hBEEF, 1'b0};
        vecs[1]  = '{"ld_a5",  1'b0, 16'h00A5, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2]  = '{"st_01",  1'b1, 16'h0001, 16'h1111, 16'h1111, 1'b0};
        vecs[3]  = '{"st_02",  1'b1, 16'h0002, 16'h2222, 16'h2222, 1'b0};
        vecs[4]  = '{"st_10",  1'b1, 16'h0010, 16'h5555, 16'h5555, 1'b0};
        vecs[5]  = '{"st_05",  1'b1, 16'h0005, 16'h0042, 16'h0042, 1'b0};
`ifdef MEM_BOUNDS_CHECK_EN
        vecs[6]  = '{"st_105", 1'b1, 16'h0105, 16'hFFFF, 16'h0000, 1'b1};
        vecs[7]  = '{"ld_05",  1'b0, 16'h0005, 16'h0000, 16'h0042, 1'b0};
`else
        vecs[6]  = '{"st_105", 1'b1, 16'h0105, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[7]  = '{"ld_05",  1'b0, 16'h0005, 16'h0000, 16'hFFFF, 1'b0};
`endif
        vecs[8]  = '{"st_ff",  1'b1, 16'h00FF, 16'h7777, 16'h7777, 1'b0};
        vecs[9]  = '{"ld_ff",  1'b0, 16'h00FF, 16'h0000, 16'h7777, 1'b0};
        vecs[10] = '{"st_00",  1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b0};
        vecs[11] = '{"ld_00",  1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ready", 16'(req_ready), 16'd0);
        chk("rst valid", 16'(resp_valid), 16'd0);
        chk("rst rdata", resp_rdata, 16'h0000);
        chk("rst error", 16'(resp_error), 16'd0);
        chk("rst ready1", 16'(rdy1), 16'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst ready", 16'(req_ready), 16'd1);
        chk("post_rst valid", 16'(resp_valid), 16'd0);

        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i]);
        end

        // Back-to-back loads with valid held across the busy cycle.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0001;
        @(posedge clk);
        #1 req_addr = 16'h0002;
        @(negedge clk);
        chk("b2b c1 valid", 16'(resp_valid), 16'd0);
        chk("b2b c1 ready", 16'(req_ready), 16'd0);
        @(negedge clk);
        chk("b2b c2 valid", 16'(resp_valid), 16'd1);
        chk("b2b c2 rdata", resp_rdata, 16'h1111);
        chk("b2b c2 ready", 16'(req_ready), 16'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b c3 valid", 16'(resp_valid), 16'd0);
        chk("b2b c3 rdata_hold", resp_rdata, 16'h1111);
        @(negedge clk);
        chk("b2b c4 valid", 16'(resp_valid), 16'd1);
        chk("b2b c4 rdata", resp_rdata, 16'h2222);
        @(negedge clk);
        chk("b2b c5 valid", 16'(resp_valid), 16'd0);

        // Reset while a store is in flight: no response, no commit.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0010;
        req_wdata = 16'h1234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        chk("rstmid c1 valid", 16'(resp_valid), 16'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rstmid c2 valid", 16'(resp_valid), 16'd0);
        chk("rstmid c2 ready", 16'(req_ready), 16'd1);
        do_req('{"ld_10_after_rst", 1'b0, 16'h0010, 16'h0000,
                 16'h5555, 1'b0});

        // LATENCY=1: four held stores then four held loads.
        @(negedge clk);
        v1 = 1'b1;
        w1 = 1'b1;
        a1 = 16'h0020;
        d1 = 16'hA000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i < 3) begin
                a1 = 16'h0021 + 16'(i);
                d1 = 16'hA001 + 16'(i);
            end else begin
                w1 = 1'b0;
                a1 = 16'h0020;
            end
            @(negedge clk);
            chk($sformatf("l1 st%0d valid", i), 16'(rv1), 16'd1);
            chk($sformatf("l1 st%0d rdata", i), rd1, 16'hA000 + 16'(i));
            chk($sformatf("l1 st%0d ready", i), 16'(rdy1), 16'd1);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i < 3) begin
                a1 = 16'h0021 + 16'(i);
            end else begin
                v1 = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("l1 ld%0d valid", i), 16'(rv1), 16'd1);
            chk($sformatf("l1 ld%0d rdata", i), rd1, 16'hA000 + 16'(i));
            chk($sformatf("l1 ld%0d ready", i), 16'(rdy1), 16'd1);
        end
        @(negedge clk);
        chk("l1 end valid", 16'(rv1), 16'd0);
        chk("l1 end rdata_hold", rd1, 16'hA003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
